reg_file: RTL and testbench

- Register file sitting directly upstream of the ALU; sources the ALU's `register1`/`register2` operands from two asynchronous read ports.
- Loads registers from the shared 32-bit tri-state bus and can drive any register back onto the bus.
- Holds a flags register that captures the ALU's `carry_flag`/`zero_flag` outputs under control, for use by the control unit.

---
 rtl/procco_pkg.sv | 15 +
 rtl/flags_reg.sv | 31 +++
 rtl/reg_file.sv | 85 ++++++++
 tb/tb_reg_file.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/procco_pkg.sv
// Shared processor definitions: datapath width, default register count,
// the word type and the ALU flags structure used by reg_file and control.
package procco_pkg;

  localparam int DATA_W        = 32;
  localparam int NREGS_DEFAULT = 8;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/flags_reg.sv
// Two-bit ALU flags register with load enable and synchronous active-low reset.
module flags_reg
  import procco_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_en,
  input  flags_t flags_in,
  output flags_t flags_out
);

  flags_t flags_d;
  flags_t flags_q;

  // NOTE: defaulting flags_d to the current state before the conditional
  // update keeps this always_comb free of latches.
  always_comb begin
    flags_d = flags_q;
    if (load_en) flags_d = flags_in;
  end

  // NOTE: state flops use non-blocking assignments; combinational blocks use
  // blocking ones.
  always_ff @(posedge clk) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign flags_out = flags_q;

endmodule

// File: rtl/reg_file.sv
// ALU-side register file: two combinational read ports, bus load/drive, flags.
// Optional REG0_ZERO_EN hardwires register 0 to zero with no storage for it.
module reg_file #(
  parameter  int NREGS  = procco_pkg::NREGS_DEFAULT,
  parameter  int DATA_W = procco_pkg::DATA_W,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] register1,
  output logic [DATA_W-1:0] register2,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              RF_read,
  input  logic              RF_write,
  inout  tri   [DATA_W-1:0] bus,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              flags_load,
  output logic              carry_q,
  output logic              zero_q
);

  import procco_pkg::*;

`ifdef REG0_ZERO_EN
  localparam bit REG0_ZERO = 1'b1;
`else
  localparam bit REG0_ZERO = 1'b0;
`endif
  // Entry 0 is left out of the array entirely when it is hardwired.
  localparam int FIRST = REG0_ZERO ? 1 : 0;

  logic [DATA_W-1:0] regs_q [FIRST:NREGS-1];
  logic [DATA_W-1:0] regs_d [FIRST:NREGS-1];
  logic [DATA_W-1:0] bus_rd_val;
  flags_t            flags_in;
  flags_t            flags_out;

  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    if (REG0_ZERO && addr == '0) return '0;
    return regs_q[addr];
  endfunction

  always_comb begin
    register1  = read_reg(rd_addr_a);
    register2  = read_reg(rd_addr_b);
    bus_rd_val = read_reg(bus_addr);
  end

  assign bus = RF_write ? bus_rd_val : {DATA_W{1'bz}};

  // Load samples the resolved bus, so RF_read with RF_write reloads the same value.
  always_comb begin
    regs_d = regs_q;
    for (int i = FIRST; i < NREGS; i++) begin
      if (RF_read && bus_addr == ADDR_W'(i)) regs_d[i] = bus;
    end
  end

  // NOTE: the array is reset explicitly because software relies on every
  // register reading zero after reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = FIRST; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = FIRST; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign flags_in = '{carry: carry_in, zero: zero_in};

  flags_reg u_flags (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (flags_load),
    .flags_in  (flags_in),
    .flags_out (flags_out)
  );

  assign carry_q = flags_out.carry;
  assign zero_q  = flags_out.zero;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based reference model. Honours REG0_ZERO_EN.
module tb_reg_file;

  localparam int NR = 8;
  localparam int AW = 3;

`ifdef REG0_ZERO_EN
  localparam bit Z0 = 1'b1;
`else
  localparam bit Z0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, bus_addr;
  logic          RF_read, RF_write;
  logic [31:0]   register1, register2;
  logic          carry_in, zero_in, flags_load;
  logic          carry_q, zero_q;
  logic          drv_en;
  logic [31:0]   drv_val;
  tri0  [31:0]   bus;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [NR];
  logic        m_carry, m_zero;

  assign bus = drv_en ? drv_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  reg_file dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .register1  (register1),
    .register2  (register2),
    .bus_addr   (bus_addr),
    .RF_read    (RF_read),
    .RF_write   (RF_write),
    .bus        (bus),
    .carry_in   (carry_in),
    .zero_in    (zero_in),
    .flags_load (flags_load),
    .carry_q    (carry_q),
    .zero_q     (zero_q)
  );

  function automatic logic [31:0] m_read(input int a);
    if (Z0 && a == 0) return 32'h0;
    return m_regs[a];
  endfunction

  // What the bus should carry this cycle given who is driving it.
  function automatic logic [31:0] m_bus();
    if (RF_write) return m_read(int'(bus_addr));
    if (drv_en)   return drv_val;
    return 32'h0;
  endfunction

  // One rising edge; the model applies the same edge's rules, then inputs settle.
  task automatic step();
    logic [31:0] bv;
    bv = m_bus();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
    end else begin
      if (RF_read && !(Z0 && bus_addr == 0)) m_regs[bus_addr] = bv;
      if (flags_load) begin
        m_carry = carry_in;
        m_zero  = zero_in;
      end
    end
    #1;
  endtask

  task automatic idle();
    RF_read = 0; RF_write = 0; drv_en = 0; flags_load = 0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] v);
    bus_addr = a; drv_val = v; drv_en = 1; RF_read = 1; RF_write = 0;
    step();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1;
    load(3'd3, 32'hDEAD_BEEF);
    rd_addr_a = 3'd3; #1;
    total++; if (register1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL preload r3: got %h want %h", register1, 32'hDEAD_BEEF); end
    reset_n = 0; flags_load = 1; carry_in = 1; zero_in = 1;
    bus_addr = 3'd3; drv_val = 32'h1111_1111; drv_en = 1; RF_read = 1;
    step();
    idle(); reset_n = 1; #1;
    total++; if (register1 !== 32'h0) begin bad++; $display("FAIL reset r3: got %h want 0", register1); end
    total++; if (carry_q !== 1'b0 || zero_q !== 1'b0) begin bad++; $display("FAIL reset flags: got c=%b z=%b want 0 0", carry_q, zero_q); end
  endtask

  task automatic test_load();
    rd_addr_b = 3'd5;
    load(3'd5, 32'h0BAD_F00D);
    bus_addr = 3'd5; drv_val = 32'h1234_5678; drv_en = 1; RF_read = 1; #1;
    total++; if (register2 !== 32'h0BAD_F00D) begin bad++; $display("FAIL load same-cycle: got %h want %h", register2, 32'h0BAD_F00D); end
    step();
    idle(); #1;
    total++; if (register2 !== 32'h1234_5678) begin bad++; $display("FAIL load next-cycle: got %h want %h", register2, 32'h1234_5678); end
  endtask

  task automatic test_drive();
    load(3'd2, 32'hA5A5_A5A5);
    bus_addr = 3'd2; RF_write = 1; #1;
    total++; if (bus !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bus drive: got %h want %h", bus, 32'hA5A5_A5A5); end
    RF_write = 0; #1;
    total++; if (bus !== 32'h0) begin bad++; $display("FAIL bus release: got %h want 0", bus); end
    load(3'd4, 32'hCAFE_0001);
    bus_addr = 3'd4; RF_read = 1; step(); idle();
    rd_addr_a = 3'd4; #1;
    total++; if (register1 !== 32'h0) begin bad++; $display("FAIL undriven load: got %h want 0", register1); end
  endtask

  task automatic test_rw_same();
    load(3'd6, 32'h0000_FFFF);
    bus_addr = 3'd6; RF_read = 1; RF_write = 1; #1;
    total++; if (bus !== 32'h0000_FFFF) begin bad++; $display("FAIL rw bus: got %h want %h", bus, 32'h0000_FFFF); end
    step();
    idle(); rd_addr_a = 3'd6; #1;
    total++; if (register1 !== 32'h0000_FFFF) begin bad++; $display("FAIL rw hold: got %h want %h", register1, 32'h0000_FFFF); end
  endtask

  task automatic test_flags();
    carry_in = 1; zero_in = 0; flags_load = 1;
    step();
    flags_load = 0; carry_in = 0; zero_in = 1;
    total++; if (carry_q !== 1'b1 || zero_q !== 1'b0) begin bad++; $display("FAIL flags load: got c=%b z=%b want 1 0", carry_q, zero_q); end
    repeat (3) step();
    total++; if (carry_q !== 1'b1 || zero_q !== 1'b0) begin bad++; $display("FAIL flags hold: got c=%b z=%b want 1 0", carry_q, zero_q); end
    carry_in = 0; zero_in = 1; flags_load = 1;
    load(3'd1, 32'h7777_0000);
    rd_addr_a = 3'd1; #1;
    total++; if (carry_q !== 1'b0 || zero_q !== 1'b1 || register1 !== 32'h7777_0000) begin bad++; $display("FAIL flags+load: got c=%b z=%b r1=%h want 0 1 77770000", carry_q, zero_q, register1); end
  endtask

  task automatic test_reg0();
    logic [31:0] exp0;
    exp0 = Z0 ? 32'h0 : 32'hFFFF_FFFF;
    load(3'd0, 32'hFFFF_FFFF);
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; #1;
    total++; if (register1 !== exp0 || register2 !== exp0) begin bad++; $display("FAIL reg0 read: got %h/%h want %h", register1, register2, exp0); end
    bus_addr = 3'd0; RF_write = 1; #1;
    total++; if (bus !== exp0) begin bad++; $display("FAIL reg0 drive: got %h want %h", bus, exp0); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n    = ($urandom_range(39) != 0);
      rd_addr_a  = AW'($urandom_range(NR - 1));
      rd_addr_b  = AW'($urandom_range(NR - 1));
      bus_addr   = AW'($urandom_range(NR - 1));
      RF_write   = ($urandom_range(3) == 0);
      drv_en     = !RF_write && ($urandom_range(5) != 0);
      drv_val    = $urandom;
      RF_read    = $urandom_range(1);
      flags_load = $urandom_range(1);
      carry_in   = $urandom_range(1);
      zero_in    = $urandom_range(1);
      #1;
      total++;
      if (register1 !== m_read(int'(rd_addr_a)) || register2 !== m_read(int'(rd_addr_b)) ||
          bus !== m_bus() || carry_q !== m_carry || zero_q !== m_zero) begin
        bad++;
        $display("FAIL random[%0d]: got r1=%h r2=%h bus=%h c=%b z=%b want r1=%h r2=%h bus=%h c=%b z=%b",
                 n, register1, register2, bus, carry_q, zero_q,
                 m_read(int'(rd_addr_a)), m_read(int'(rd_addr_b)), m_bus(), m_carry, m_zero);
      end
      step();
    end
    reset_n = 1;
    idle();
  endtask

  initial begin
    reset_n = 0; rd_addr_a = 0; rd_addr_b = 0; bus_addr = 0;
    carry_in = 0; zero_in = 0; drv_val = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    m_carry = 0; m_zero = 0;
    idle();
    #2;
    repeat (2) step();
    test_reset();
    test_load();
    test_drive();
    test_rw_same();
    test_flags();
    test_reg0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
